// File: rtl/varredura_tabuleiro_pkg.sv
// varredura_tabuleiro_pkg: board geometry, scanner FSM states and small helpers
package varredura_tabuleiro_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int RW   = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_RELEASE  = 2'd3
    } estado_t;

    function automatic logic [ROWS-1:0] row_onehot(input logic [RW-1:0] idx);
        return ROWS'(1) << idx;
    endfunction

    // more than one column active in the same sample
    function automatic logic multiplas(input logic [COLS-1:0] c);
        return (c & (c - COLS'(1))) != '0;
    endfunction
endpackage

// File: rtl/sincronizador_2ff.sv
// sincronizador_2ff: width-parameterised two-flop synchroniser for asynchronous inputs
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/varredura_tabuleiro.sv
// varredura_tabuleiro: scans a 4x4 board switch matrix and emits one debounced move per key press
module varredura_tabuleiro
    import varredura_tabuleiro_pkg::*;
#(
    parameter int SCAN_DWELL = 4,
    parameter int DEBOUNCE   = 50000,
    parameter int PULSE_LEN  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            habilitar,
    input  logic [COLS-1:0] colunas_tab,
    output logic [ROWS-1:0] linhas_tab,
    output logic [ROWS-1:0] jogadaFileira,
    output logic [COLS-1:0] jogadaColuna,
    output logic            temJogada,
    output logic            db_multipla,
    output logic [1:0]      db_estado
);
    localparam int DW = $clog2(SCAN_DWELL);
    localparam int BW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    estado_t         estado, estado_d;
    logic [RW-1:0]   row, row_d;
    logic [DW-1:0]   dwell, dwell_d;
    logic [BW-1:0]   deb, deb_d;
    logic [PW-1:0]   pul, pul_d;
    logic [COLS-1:0] cols, cand, cand_d;
    logic [ROWS-1:0] linhas_d, fil_d;
    logic [COLS-1:0] col_d;
    logic            tem_d, mult_d;

    sincronizador_2ff #(.W(COLS)) u_sinc (
        .clock(clock),
        .reset(reset),
        .d    (colunas_tab),
        .q    (cols)
    );

    assign db_estado = estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= ST_SCAN;
            row           <= '0;
            dwell         <= '0;
            deb           <= '0;
            pul           <= '0;
            cand          <= '0;
            linhas_tab    <= ROWS'(1);
            jogadaFileira <= '0;
            jogadaColuna  <= '0;
            temJogada     <= 1'b0;
            db_multipla   <= 1'b0;
        end else begin
            estado        <= estado_d;
            row           <= row_d;
            dwell         <= dwell_d;
            deb           <= deb_d;
            pul           <= pul_d;
            cand          <= cand_d;
            linhas_tab    <= linhas_d;
            jogadaFileira <= fil_d;
            jogadaColuna  <= col_d;
            temJogada     <= tem_d;
            db_multipla   <= mult_d;
        end
    end

    // counters only advance while below their terminal value, so they never wrap
    always_comb begin
        estado_d = estado;
        row_d    = row;
        dwell_d  = '0;
        deb_d    = '0;
        pul_d    = '0;
        cand_d   = cand;
        fil_d    = jogadaFileira;
        col_d    = jogadaColuna;
        mult_d   = 1'b0;
        case (estado)
            ST_SCAN: begin
                if (dwell != DW'(SCAN_DWELL - 1)) begin
                    dwell_d = dwell + DW'(1);
                end else if (cols != '0 && !multiplas(cols)) begin
                    estado_d = ST_DEBOUNCE;
                    cand_d   = cols;
                end else begin
                    row_d  = row + RW'(1);
                    mult_d = multiplas(cols);
                end
            end
            ST_DEBOUNCE: begin
                if (cols != cand) begin
                    estado_d = ST_SCAN;
                end else if (deb == BW'(DEBOUNCE - 1)) begin
                    estado_d = ST_EMIT;
                    fil_d    = row_onehot(row);
                    col_d    = cand;
                end else begin
                    deb_d = deb + BW'(1);
                end
            end
            ST_EMIT: begin
                estado_d = pul == PW'(PULSE_LEN - 1) ? ST_RELEASE : ST_EMIT;
                pul_d    = pul == PW'(PULSE_LEN - 1) ? '0 : pul + PW'(1);
            end
            default: begin
                if (cols == '0 && deb == BW'(DEBOUNCE - 1)) begin
                    estado_d = ST_SCAN;
                    row_d    = row + RW'(1);
                end else if (cols == '0) begin
                    deb_d = deb + BW'(1);
                end
            end
        endcase
        if (!habilitar) begin
            estado_d = ST_SCAN;
            row_d    = '0;
            dwell_d  = '0;
            deb_d    = '0;
            pul_d    = '0;
            mult_d   = 1'b0;
        end
        linhas_d = habilitar ? row_onehot(row_d) : '0;
        tem_d    = estado_d == ST_EMIT;
    end
endmodule

// File: tb/tb_varredura_tabuleiro.sv
// tb_varredura_tabuleiro: key-matrix model plus move scoreboard for the board scanner
module tb_varredura_tabuleiro;
    localparam int PULSE_LEN = 2;

    logic       clock, reset, habilitar;
    logic [3:0] colunas_tab, linhas_tab, jogadaFileira, jogadaColuna;
    logic       temJogada, db_multipla;
    logic [1:0] db_estado;

    logic [3:0] tecla [4];
    logic [7:0] esperado [$];
    int checks, errors, pulsos, mult_cnt, largura;
    logic tem_ant, mult_ant;

    typedef struct {
        int         linha;
        logic [3:0] cols;
        int         hold;
        int         pulso;
        int         mult;
        logic [3:0] ef;
        logic [3:0] ec;
    } vetor_t;
    vetor_t v [8];

    varredura_tabuleiro #(.SCAN_DWELL(4), .DEBOUNCE(8), .PULSE_LEN(PULSE_LEN)) dut (
        .clock        (clock),
        .reset        (reset),
        .habilitar    (habilitar),
        .colunas_tab  (colunas_tab),
        .linhas_tab   (linhas_tab),
        .jogadaFileira(jogadaFileira),
        .jogadaColuna (jogadaColuna),
        .temJogada    (temJogada),
        .db_multipla  (db_multipla),
        .db_estado    (db_estado)
    );

    // a closed switch connects its driven row to its column
    assign colunas_tab = (linhas_tab[0] ? tecla[0] : 4'b0) | (linhas_tab[1] ? tecla[1] : 4'b0)
                       | (linhas_tab[2] ? tecla[2] : 4'b0) | (linhas_tab[3] ? tecla[3] : 4'b0);

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] exp);
        checks++;
        if (atual !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, atual, exp);
        end
    endtask

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic solta();
        for (int r = 0; r < 4; r++) tecla[r] = 4'b0;
    endtask

    always @(negedge clock) begin : monitor
        logic [7:0] e;
        if (temJogada && !tem_ant) begin
            pulsos++;
            largura = 1;
            if (esperado.size() == 0) begin
                chk("pulso_inesperado", {jogadaFileira, jogadaColuna}, 0);
            end else begin
                e = esperado.pop_front();
                chk("jogada", {jogadaFileira, jogadaColuna}, e);
            end
        end else if (temJogada) begin
            largura++;
        end else if (tem_ant) begin
            chk("largura_pulso", largura, PULSE_LEN);
        end
        if (db_multipla) mult_cnt++;
        if (db_multipla && mult_ant) chk("multipla_1ciclo", 1, 0);
        tem_ant  = temJogada;
        mult_ant = db_multipla;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0, m0;
        logic achou;
        v[0] = '{2, 4'b0010, 40, 1, 0, 4'b0100, 4'b0010};
        v[1] = '{0, 4'b0001, 40, 1, 0, 4'b0001, 4'b0001};
        v[2] = '{1, 4'b0100, 40, 1, 0, 4'b0010, 4'b0100};
        v[3] = '{3, 4'b1000, 40, 1, 0, 4'b1000, 4'b1000};
        v[4] = '{0, 4'b0110, 40, 0, 1, 4'b1000, 4'b1000};
        v[5] = '{3, 4'b1001, 40, 0, 1, 4'b1000, 4'b1000};
        v[6] = '{1, 4'b0001, 6,  0, 0, 4'b1000, 4'b1000};
        v[7] = '{2, 4'b1000, 40, 1, 0, 4'b0100, 4'b1000};
        checks = 0; errors = 0; pulsos = 0; mult_cnt = 0; largura = 0;
        tem_ant = 1'b0; mult_ant = 1'b0;
        solta();
        reset = 1'b0;
        habilitar = 1'b1;
        #3 reset = 1'b1;
        #2;
        chk("reset_linhas", linhas_tab, 4'b0001);
        chk("reset_jogada", {jogadaFileira, jogadaColuna}, 0);
        chk("reset_flags", {temJogada, db_multipla}, 0);
        chk("reset_estado", db_estado, 0);
        @(negedge clock) reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            if (k == 3) chk("scan_dwell", linhas_tab, 4'b0001);
            if (k % 4 == 0) chk($sformatf("scan_linha_%0d", k / 4), linhas_tab, 4'b0001 << ((k / 4) % 4));
        end

        for (int i = 0; i < 8; i++) begin
            p0 = pulsos;
            m0 = mult_cnt;
            if (v[i].pulso != 0) esperado.push_back({v[i].ef, v[i].ec});
            tecla[v[i].linha] = v[i].cols;
            espera(v[i].hold);
            solta();
            espera(30);
            chk($sformatf("vetor%0d_pulsos", i), pulsos - p0, v[i].pulso);
            chk($sformatf("vetor%0d_multipla", i), (mult_cnt - m0) != 0, v[i].mult);
            chk($sformatf("vetor%0d_jogada", i), {jogadaFileira, jogadaColuna}, {v[i].ef, v[i].ec});
        end

        p0 = pulsos;
        for (int i = 0; i < 10; i++) begin
            tecla[2][1] = ~tecla[2][1];
            espera(3);
        end
        chk("bounce_sem_pulso", pulsos - p0, 0);
        esperado.push_back({4'b0100, 4'b0010});
        tecla[2] = 4'b0010;
        espera(40);
        chk("bounce_um_pulso", pulsos - p0, 1);
        solta();
        espera(30);

        p0 = pulsos;
        esperado.push_back({4'b0100, 4'b0010});
        tecla[2] = 4'b0010;
        espera(40);
        chk("repress_primeiro", pulsos - p0, 1);
        tecla[2] = 4'b0;
        espera(5);
        tecla[2] = 4'b0010;
        espera(30);
        chk("repress_estado", db_estado, 3);
        chk("repress_sem_pulso", pulsos - p0, 1);
        solta();
        espera(20);
        chk("solto_estado", db_estado, 0);
        esperado.push_back({4'b1000, 4'b1000});
        tecla[3] = 4'b1000;
        espera(40);
        chk("novo_pulso_33", pulsos - p0, 2);
        solta();
        espera(30);

        p0 = pulsos;
        achou = 1'b0;
        tecla[2] = 4'b0100;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #5;
            if (db_estado == 2'd1) begin
                achou = 1'b1;
                break;
            end
        end
        chk("espera_debounce", achou, 1);
        habilitar = 1'b0;
        @(posedge clock);
        #1;
        chk("desab_tem", temJogada, 0);
        chk("desab_linhas", linhas_tab, 4'b0000);
        chk("desab_estado", db_estado, 0);
        espera(12);
        chk("desab_parado", {linhas_tab, 2'b00, db_estado}, 0);
        chk("desab_retida", {jogadaFileira, jogadaColuna}, {4'b1000, 4'b1000});
        chk("desab_sem_pulso", pulsos - p0, 0);
        solta();
        habilitar = 1'b1;
        @(posedge clock);
        #1;
        chk("reab_linha0", linhas_tab, 4'b0001);
        repeat (3) @(posedge clock);
        #1;
        chk("reab_dwell", linhas_tab, 4'b0010);
        espera(20);

        achou = 1'b0;
        tecla[1] = 4'b0001;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #5;
            if (temJogada) begin
                achou = 1'b1;
                break;
            end
        end
        chk("espera_emit", achou, 1);
        reset = 1'b1;
        #1;
        chk("rst_emit_tem", temJogada, 0);
        chk("rst_emit_linhas", linhas_tab, 4'b0001);
        chk("rst_emit_estado", db_estado, 0);
        chk("rst_emit_jogada", {jogadaFileira, jogadaColuna}, 0);
        solta();
        @(negedge clock) reset = 1'b0;
        p0 = pulsos;
        espera(30);
        chk("rst_sem_pulso", pulsos - p0, 0);

        chk("fila_vazia", esperado.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
